// File: rtl/kof_input_ctrl.sv
// -----------------------------------------------------------------------------
// kof_input_ctrl
//
// Frame-synchronous player input stage. Once per video frame the eight USB HID
// keycode slots are captured, mapped onto two players' action bits, cleaned of
// contradictory directions, and presented as held levels, new-press levels and
// a per-player quarter-circle-forward + punch special-move flag. Every output
// changes only on the frame update cycle, so downstream motion logic sees a
// stable value for a whole frame.
//
// Build option:
//   INPUT_COMBO_EN  defined   -> combo FSMs are built, p1/p2_special are live.
//                   undefined -> no combo logic, p1/p2_special tied to 0.
//
// Parameters:
//   COMBO_WINDOW      max frames between combo steps before giving up (1..63)
//
// Ports:
//   Clk               system clock (100 MHz)
//   reset_rtl_0       synchronous active-low reset
//   keycode0          HID slots 0-3 (slot 0 = bits 7:0)
//   keycode1          HID slots 4-7
//   frame_clk         vsync level, asynchronous to Clk
//   p1_facing_right   P1 orientation (selects the forward direction)
//   p2_facing_right   P2 orientation
//   p1_held/p2_held   cleaned levels {kick,punch,down,up,right,left}
//   p1_pressed/...    held this frame and not held last frame
//   p1_special/...    special move completed this frame
//   frame_valid       one-cycle pulse when the outputs above were updated
//
// Frame pipeline (E0 = Clk edge that first samples frame_clk high):
//   E1 sync2 high, E2 tick registered, E3 keycodes captured,
//   E4 outputs updated and frame_valid high for one cycle.
// -----------------------------------------------------------------------------
module kof_input_ctrl #(
  parameter int unsigned COMBO_WINDOW = 12
) (
  input  logic        Clk,
  input  logic        reset_rtl_0,
  input  logic [31:0] keycode0,
  input  logic [31:0] keycode1,
  input  logic        frame_clk,
  input  logic        p1_facing_right,
  input  logic        p2_facing_right,
  output logic [5:0]  p1_held,
  output logic [5:0]  p2_held,
  output logic [5:0]  p1_pressed,
  output logic [5:0]  p2_pressed,
  output logic        p1_special,
  output logic        p2_special,
  output logic        frame_valid
);

  // Action bit positions inside a 6-bit action vector.
  localparam int unsigned BIT_LEFT  = 0;
  localparam int unsigned BIT_RIGHT = 1;
  localparam int unsigned BIT_UP    = 2;
  localparam int unsigned BIT_DOWN  = 3;

  localparam logic [7:0] ROLLOVER_CODE = 8'h01;

  // Fixed HID usage codes, [player][action]; player 0 = P1.
  // Each row is listed kick, punch, down, up, right, left (MSB first).
  localparam logic [1:0][5:0][7:0] KEY_MAP = {
    {8'h5A, 8'h59, 8'h51, 8'h52, 8'h4F, 8'h50},   // P2
    {8'h0E, 8'h0D, 8'h16, 8'h1A, 8'h07, 8'h04}    // P1
  };

  // ---------------------------------------------------------------------------
  // frame_clk synchronizer, rising-edge detector and capture pipeline
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q, edge_q;
  logic [1:0]      fill_q;     // marks which sync flops hold real samples
  logic            armed_q, armed_d;
  logic            tick_q, tick_d;
  logic            decode_q;
  logic [7:0][7:0] keys_q;

  // A rise only counts once frame_clk has been seen low after reset, so a
  // vsync already high at release does not produce a spurious tick.
  assign armed_d = armed_q | (fill_q[1] & ~sync2_q);
  assign tick_d  = armed_q & sync2_q & ~edge_q;

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      edge_q   <= 1'b0;
      fill_q   <= 2'b00;
      armed_q  <= 1'b0;
      tick_q   <= 1'b0;
      decode_q <= 1'b0;
      // NOTE: the capture register is only 64 bits, so it is reset like any
      // other flop; it would not be for a real RAM array.
      keys_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a shift chain.
      sync1_q  <= frame_clk;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      fill_q   <= {fill_q[0], 1'b1};
      armed_q  <= armed_d;
      tick_q   <= tick_d;
      decode_q <= tick_q;
      if (tick_q) begin
        keys_q <= {keycode1, keycode0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Key decode and SOCD cleaning (operates on the captured slots)
  // ---------------------------------------------------------------------------
  logic [1:0][5:0] raw_keys;
  logic [1:0][5:0] clean_keys;
  logic            rollover;

  always_comb begin
    // NOTE: every variable gets a default before the loops so that no path
    // leaves it unassigned and no latch is inferred.
    raw_keys = '0;
    rollover = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (keys_q[s] == ROLLOVER_CODE) begin
        rollover = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < 6; b++) begin
          if (keys_q[s] == KEY_MAP[p][b]) begin
            raw_keys[p][b] = 1'b1;
          end
        end
      end
    end
  end

  // Left+right cancels both; up+down keeps down (crouch wins over jump).
  always_comb begin
    clean_keys = raw_keys;
    for (int p = 0; p < 2; p++) begin
      if (raw_keys[p][BIT_LEFT] && raw_keys[p][BIT_RIGHT]) begin
        clean_keys[p][BIT_LEFT]  = 1'b0;
        clean_keys[p][BIT_RIGHT] = 1'b0;
      end
      if (raw_keys[p][BIT_UP] && raw_keys[p][BIT_DOWN]) begin
        clean_keys[p][BIT_UP] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Held / pressed output registers
  // ---------------------------------------------------------------------------
  logic [1:0][5:0] held_q, held_d;
  logic [1:0][5:0] pressed_q, pressed_d;
  logic            frame_valid_q;
  logic            update;

  // A rollover frame still pulses frame_valid but changes no state.
  assign update    = decode_q & ~rollover;
  assign held_d    = clean_keys;
  assign pressed_d = clean_keys & ~held_q;

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      held_q        <= '0;
      pressed_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= decode_q;
      if (update) begin
        held_q    <= held_d;
        pressed_q <= pressed_d;
      end
    end
  end

  assign p1_held     = held_q[0];
  assign p2_held     = held_q[1];
  assign p1_pressed  = pressed_q[0];
  assign p2_pressed  = pressed_q[1];
  assign frame_valid = frame_valid_q;

`ifdef INPUT_COMBO_EN
  // ---------------------------------------------------------------------------
  // Quarter-circle-forward + punch detector, one per player
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    COMBO_IDLE,
    COMBO_DOWN,
    COMBO_DOWNFWD
  } combo_state_e;

  localparam int unsigned     BIT_PUNCH = 4;
  localparam int unsigned     CNT_W     = $clog2(COMBO_WINDOW + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(COMBO_WINDOW);

  combo_state_e     state_q [2];
  combo_state_e     state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [CNT_W-1:0] cnt_inc [2];
  logic [1:0]       facing;
  logic [1:0]       fwd_held, back_held, punch_new, timeout;
  logic [1:0]       fire_d;
  logic [1:0]       special_q;

  assign facing = {p2_facing_right, p1_facing_right};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_held[p]  = facing[p] ? clean_keys[p][BIT_RIGHT] : clean_keys[p][BIT_LEFT];
      back_held[p] = facing[p] ? clean_keys[p][BIT_LEFT]  : clean_keys[p][BIT_RIGHT];
      punch_new[p] = pressed_d[p][BIT_PUNCH];
      // Saturating frame count since the current state was entered.
      cnt_inc[p]   = (cnt_q[p] == CNT_MAX) ? cnt_q[p] : cnt_q[p] + 1'b1;
      timeout[p]   = (cnt_inc[p] > CNT_LIMIT);
    end
  end

  // Back input and window expiry abort before any forward step or fire is
  // considered; the fire can only happen from DOWNFWD, so a punch in the same
  // frame that reaches DOWNFWD never fires.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      fire_d[p]  = 1'b0;
      if (update) begin
        case (state_q[p])
          COMBO_IDLE: begin
            if (clean_keys[p][BIT_DOWN]) begin
              state_d[p] = COMBO_DOWN;
              cnt_d[p]   = '0;
            end
          end
          COMBO_DOWN: begin
            if (back_held[p] || timeout[p]) begin
              state_d[p] = COMBO_IDLE;
              cnt_d[p]   = '0;
            end else if (fwd_held[p]) begin
              state_d[p] = COMBO_DOWNFWD;
              cnt_d[p]   = '0;
            end else begin
              cnt_d[p]   = cnt_inc[p];
            end
          end
          COMBO_DOWNFWD: begin
            if (back_held[p] || timeout[p]) begin
              state_d[p] = COMBO_IDLE;
              cnt_d[p]   = '0;
            end else if (punch_new[p]) begin
              state_d[p] = COMBO_IDLE;
              cnt_d[p]   = '0;
              fire_d[p]  = 1'b1;
            end else begin
              cnt_d[p]   = cnt_inc[p];
            end
          end
          default: begin
            state_d[p] = COMBO_IDLE;
            cnt_d[p]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= COMBO_IDLE;
        cnt_q[p]   <= '0;
      end
      special_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
      if (update) begin
        special_q <= fire_d;
      end
    end
  end

  assign p1_special = special_q[0];
  assign p2_special = special_q[1];
`else
  // Orientation and window only matter to the combo detector.
  localparam int unsigned unused_combo_window = COMBO_WINDOW;
  logic unused_facing;

  assign unused_facing = p1_facing_right ^ p2_facing_right;
  assign p1_special    = 1'b0;
  assign p2_special    = 1'b0;
`endif

endmodule

// File: tb/tb_kof_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kof_input_ctrl
//
// Directed bench for kof_input_ctrl. Each frame task pushes the hand-computed
// expected outputs into a queue; an independent monitor pops and compares
// whenever frame_valid is seen. Special-move expectations follow the build
// option INPUT_COMBO_EN (forced to 0 when the detector is not built).
// -----------------------------------------------------------------------------
module tb_kof_input_ctrl;

`ifdef INPUT_COMBO_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  localparam int unsigned WINDOW = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] keycode0, keycode1;
  logic        frame_clk;
  logic        p1_facing_right, p2_facing_right;
  logic [5:0]  p1_held, p2_held, p1_pressed, p2_pressed;
  logic        p1_special, p2_special, frame_valid;

  always #5 clk = ~clk;

  kof_input_ctrl #(.COMBO_WINDOW(WINDOW)) dut (
    .Clk             (clk),
    .reset_rtl_0     (rst_n),
    .keycode0        (keycode0),
    .keycode1        (keycode1),
    .frame_clk       (frame_clk),
    .p1_facing_right (p1_facing_right),
    .p2_facing_right (p2_facing_right),
    .p1_held         (p1_held),
    .p2_held         (p2_held),
    .p1_pressed      (p1_pressed),
    .p2_pressed      (p2_pressed),
    .p1_special      (p1_special),
    .p2_special      (p2_special),
    .frame_valid     (frame_valid)
  );

  typedef struct {
    string      tag;
    logic [5:0] p1h, p1p, p2h, p2p;
    logic       s1, s2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] all_outs();
    return {p1_held, p2_held, p1_pressed, p2_pressed, p1_special, p2_special, frame_valid};
  endfunction

  // Monitor: compares on every frame_valid, also checks the pulse is 1 cycle.
  logic prev_fv = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fv = 1'b0;
    end else begin
      if (frame_valid) begin
        check("frame_valid width", 32'(prev_fv), 0);
        if (exp_q.size() == 0) begin
          check("unexpected frame_valid (queue depth)", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.tag, " p1_held"},    32'(p1_held),    32'(e.p1h));
          check({e.tag, " p1_pressed"}, 32'(p1_pressed), 32'(e.p1p));
          check({e.tag, " p2_held"},    32'(p2_held),    32'(e.p2h));
          check({e.tag, " p2_pressed"}, 32'(p2_pressed), 32'(e.p2p));
          check({e.tag, " p1_special"}, 32'(p1_special), 32'(e.s1));
          check({e.tag, " p2_special"}, 32'(p2_special), 32'(e.s2));
        end
      end
      prev_fv = frame_valid;
    end
  end

  // One frame: set keys, raise vsync for 4 cycles, record frame_valid timing,
  // then make sure the monitor consumed the expectation.
  task automatic frame(input string tag, input logic [31:0] k0, input logic [31:0] k1,
                       input logic [5:0] p1h, input logic [5:0] p1p,
                       input logic [5:0] p2h, input logic [5:0] p2p,
                       input logic s1, input logic s2);
    exp_t       e;
    logic [5:0] pat;
    e.tag = tag; e.p1h = p1h; e.p1p = p1p; e.p2h = p2h; e.p2p = p2p;
    e.s1  = s1 & COMBO;
    e.s2  = s2 & COMBO;
    keycode0 = k0;
    keycode1 = k1;
    exp_q.push_back(e);
    @(negedge clk);
    frame_clk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = frame_valid;
      if (i == 3) frame_clk = 1'b0;
    end
    // frame_valid must appear 4 cycles after the first high sample, 1 wide.
    check({tag, " frame_valid timing"}, 32'(pat), 32'(6'b010000));
    repeat (4) @(negedge clk);
    check({tag, " expectation consumed"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fv_count;
    rst_n           = 1'b0;
    frame_clk       = 1'b0;
    keycode0        = 32'h0000_0004;
    keycode1        = 32'h0;
    p1_facing_right = 1'b1;
    p2_facing_right = 1'b1;

    // Reset held low while vsync pulses arrive: everything stays 0.
    repeat (3) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      frame_clk = 1'b1;
      repeat (4) begin
        @(negedge clk);
        check("outputs in reset", 32'(all_outs()), 0);
      end
      frame_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic held / pressed.
    frame("A1", 32'h04, 0, 6'b000001, 6'b000001, 0, 0, 0, 0);
    frame("A2", 32'h04, 0, 6'b000001, 6'b000000, 0, 0, 0, 0);

    // Keys changing between ticks must not disturb the outputs.
    keycode0 = 32'h07;
    keycode1 = 32'h1A;
    repeat (12) @(negedge clk);
    check("between ticks p1_held",    32'(p1_held),    32'(6'b000001));
    check("between ticks p1_pressed", 32'(p1_pressed), 0);

    // SOCD cleaning, then a rollover frame that changes nothing.
    frame("B1 socd",     32'h0704, 32'h16, 6'b001000, 6'b001000, 0, 0, 0, 0);
    frame("B2 rollover", 32'h01,   32'h16, 6'b001000, 6'b001000, 0, 0, 0, 0);

    // P1 facing right: down, down-forward, forward+punch fires once.
    frame("C1", 32'h16,   0, 6'b001000, 6'b000000, 0, 0, 0, 0);
    frame("C2", 32'h0716, 0, 6'b001010, 6'b000010, 0, 0, 0, 0);
    frame("C3", 32'h0D07, 0, 6'b010010, 6'b010000, 0, 0, 1, 0);
    frame("C4", 32'h0,    0, 6'b000000, 6'b000000, 0, 0, 0, 0);

    // Same sequence facing left: D is now back, so no special.
    p1_facing_right = 1'b0;
    frame("D1", 32'h16,   0, 6'b001000, 6'b001000, 0, 0, 0, 0);
    frame("D2", 32'h0716, 0, 6'b001010, 6'b000010, 0, 0, 0, 0);
    frame("D3", 32'h0D07, 0, 6'b010010, 6'b010000, 0, 0, 0, 0);
    frame("D4", 32'h0,    0, 6'b000000, 6'b000000, 0, 0, 0, 0);
    p1_facing_right = 1'b1;

    // P2: window expires after WINDOW+1 idle frames, punch does not fire.
    frame("E1", 32'h51, 0, 0, 0, 6'b001000, 6'b001000, 0, 0);
    frame("E2", 32'h4F, 0, 0, 0, 6'b000010, 6'b000010, 0, 0);
    for (int i = 0; i < WINDOW + 1; i++) begin
      frame($sformatf("E idle %0d", i), 32'h0, 0, 0, 0, 0, 0, 0, 0);
    end
    frame("E punch late", 32'h59, 0, 0, 0, 6'b010000, 6'b010000, 0, 0);

    // P2: punch exactly WINDOW frames after reaching down-forward still fires.
    frame("H1", 32'h51, 0, 0, 0, 6'b001000, 6'b001000, 0, 0);
    frame("H2", 32'h4F, 0, 0, 0, 6'b000010, 6'b000010, 0, 0);
    for (int i = 0; i < WINDOW - 1; i++) begin
      frame($sformatf("H idle %0d", i), 32'h0, 0, 0, 0, 0, 0, 0, 0);
    end
    frame("H punch in window", 32'h59, 0, 0, 0, 6'b010000, 6'b010000, 0, 1);

    // Remaining codes for both players spread across both slot words.
    frame("F mixed", 32'h5A52_5000, 32'h0E1A_0000,
          6'b100100, 6'b100100, 6'b100101, 6'b100101, 0, 0);

    // Reset in the middle of a combo, with vsync high across the release.
    frame("G1", 32'h16,   0, 6'b001000, 6'b001000, 0, 0, 0, 0);
    frame("G2", 32'h0716, 0, 6'b001010, 6'b000010, 0, 0, 0, 0);
    @(negedge clk);
    rst_n     = 1'b0;
    frame_clk = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("outputs in mid-combo reset", 32'(all_outs()), 0);
    end
    rst_n    = 1'b1;
    fv_count = 0;
    repeat (8) begin
      @(negedge clk);
      fv_count += int'(frame_valid);
    end
    frame_clk = 1'b0;
    repeat (6) begin
      @(negedge clk);
      fv_count += int'(frame_valid);
    end
    check("no tick when vsync high at release", fv_count, 0);
    frame("G3 after reset", 32'h0D, 0, 6'b010000, 6'b010000, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
